// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Parallel-to-serial transmitter for an asynchronous 8N1 line (UART TXD).
// A one-byte holding register sits in front of the shifter. Software can queue
// the next byte while the current frame is on the line, and that byte starts
// on the same edge the previous stop bit ends.
//
// Frame: start bit (0), eight data bits LSB first, stop bit (1). Each bit is
// BAUD_DIV clock cycles, so a frame is 10*BAUD_DIV cycles.
//
// Ports
//   CLK       system clock, all logic on posedge
//   RES       synchronous active-high reset, overrides everything
//   TX_DATA   byte to send, sampled only on a handshake edge
//   TX_VALID  TX_DATA valid; transfer when TX_VALID && TX_READY at posedge
//   TX_READY  holding register empty (register-derived, no path from TX_VALID)
//   BUSY      frame on the line or byte waiting in the holding register
//   TXD       serial output, driven directly from a flop, idles high
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int unsigned BAUD_DIV = 868
) (
   input  logic       CLK,
   input  logic       RES,
   input  logic [7:0] TX_DATA,
   input  logic       TX_VALID,
   output logic       TX_READY,
   output logic       BUSY,
   output logic       TXD
);

   localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [2:0]    bit_idx, bit_idx_d;
   logic [7:0]    shift, shift_d;
   logic [7:0]    hold, hold_d;
   logic          hold_full, hold_full_d;
   logic          txd_q, txd_d;

   logic          cnt_wrap;
   logic          accept;

   assign cnt_wrap = (cnt == CNT_MAX);
   // Ready depends only on the hold flag, so accept has no loop through TX_READY.
   assign accept   = TX_VALID && !hold_full;

   assign TX_READY = !hold_full;
   assign BUSY     = (state != IDLE) || hold_full;
   assign TXD      = txd_q;

   // State and datapath registers.
   always_ff @(posedge CLK) begin
      if (RES) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         txd_q     <= 1'b1;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         bit_idx   <= bit_idx_d;
         shift     <= shift_d;
         hold      <= hold_d;
         hold_full <= hold_full_d;
         txd_q     <= txd_d;
      end
   end

   // Next-state and next-output logic. TXD is computed one edge ahead so the
   // pad is driven straight from txd_q.
   always_comb begin
      state_d     = state;
      cnt_d       = cnt_wrap ? '0 : cnt + CW'(1);
      bit_idx_d   = bit_idx;
      shift_d     = shift;
      hold_d      = hold;
      hold_full_d = hold_full;
      txd_d       = txd_q;

      // While a frame is running, an accepted byte waits in the holding register.
      if (accept && (state != IDLE)) begin
         hold_d      = TX_DATA;
         hold_full_d = 1'b1;
      end

      case (state)
         IDLE: begin
            cnt_d = '0;
            txd_d = 1'b1;
            if (accept) begin
               // Direct load: the start bit is on the line from the handshake edge.
               shift_d = TX_DATA;
               state_d = START;
               txd_d   = 1'b0;
            end else if (hold_full) begin
               shift_d     = hold;
               hold_full_d = 1'b0;
               state_d     = START;
               txd_d       = 1'b0;
            end
         end

         START: begin
            if (cnt_wrap) begin
               state_d   = DATA;
               bit_idx_d = '0;
               txd_d     = shift[0];
            end
         end

         DATA: begin
            if (cnt_wrap) begin
               if (bit_idx == 3'd7) begin
                  state_d = STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_idx_d = bit_idx + 3'd1;
                  txd_d     = shift[bit_idx_d];
               end
            end
         end

         STOP: begin
            txd_d = 1'b1;
            if (cnt_wrap) begin
               if (hold_full) begin
                  // Chain straight into the next frame with no idle cycle.
                  shift_d     = hold;
                  hold_full_d = 1'b0;
                  state_d     = START;
                  txd_d       = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

endmodule
